// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, response error codes,
// FSM states and the load-result width adjustment.
package lsu_pkg;

  localparam int LSU_XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'b00,
    ERR_MISALIGNED = 2'b01,
    ERR_FAULT      = 2'b10,
    ERR_FUNCT3     = 2'b11
  } lsu_err_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } lsu_state_e;

  // Unsigned loads are masked here so the result is exact whatever the memory puts in the upper bits.
  function automatic logic [LSU_XLEN-1:0] load_adjust(input logic [2:0] funct3,
                                                      input logic [LSU_XLEN-1:0] data);
    case (funct3)
      F3_LBU:  return data & 32'h0000_00FF;
      F3_LHU:  return data & 32'h0000_FFFF;
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bundles the execute-side request, writeback-side response and memory-side buses of the LSU.
interface load_store_unit_if #(parameter int XLEN = 32);

  logic            req_valid;
  logic            req_ready;
  logic            req_is_store;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_base;
  logic [11:0]     req_offset;
  logic [XLEN-1:0] req_wdata;
  logic [4:0]      req_rd;
  logic            flush;

  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;
  logic [4:0]      resp_rd;
  logic [1:0]      resp_err;

  logic [2:0]      load_type;
  logic [2:0]      store_type;
  logic            mem_read_en;
  logic            mem_write_en;
  logic [XLEN-1:0] ram_address_load;
  logic [XLEN-1:0] ram_address_store;
  logic [XLEN-1:0] data_in;
  logic [XLEN-1:0] data_out;
  logic            mem_busy;

  // master is the LSU itself; slave is the surrounding pipeline and memory.
  modport master (
    input  req_valid, req_is_store, req_funct3, req_base, req_offset, req_wdata, req_rd, flush,
    input  resp_ready, data_out, mem_busy,
    output req_ready, resp_valid, resp_data, resp_rd, resp_err,
    output load_type, store_type, mem_read_en, mem_write_en,
    output ram_address_load, ram_address_store, data_in
  );

  modport slave (
    output req_valid, req_is_store, req_funct3, req_base, req_offset, req_wdata, req_rd, flush,
    output resp_ready, data_out, mem_busy,
    input  req_ready, resp_valid, resp_data, resp_rd, resp_err,
    input  load_type, store_type, mem_read_en, mem_write_en,
    input  ram_address_load, ram_address_store, data_in
  );

endinterface

// File: rtl/lsu_addr_check.sv
// Effective-address adder plus funct3, alignment and range checks; pure combinational.
module lsu_addr_check
  import lsu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_LIMIT = 4096
) (
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] base,
  input  logic [11:0]     offset,
  output logic [XLEN-1:0] addr,
  output lsu_err_e        err
);

  logic illegal;
  logic misaligned;
  logic fault;

  // Error priority: illegal funct3 first, then alignment, then range.
  always_comb begin
    addr    = base + {{(XLEN-12){offset[11]}}, offset};
    illegal = is_store ? (funct3 > F3_SW) : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
    case (funct3[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    fault = (addr >= XLEN'(ADDR_LIMIT));
    if (illegal)         err = ERR_FUNCT3;
    else if (misaligned) err = ERR_MISALIGNED;
    else if (fault)      err = ERR_FAULT;
    else                 err = ERR_NONE;
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request, checks it, runs the one-cycle strobe / busy
// handshake with data memory and hands a width-adjusted result to writeback.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_LIMIT = 4096,
  parameter int XLEN       = 32
) (
  input logic                clk,
  input logic                rst_n,
  load_store_unit_if.master  bus
);

  lsu_state_e      state;
  logic            dropped;
  logic            is_store_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] chk_addr;
  lsu_err_e        chk_err;

  lsu_addr_check #(
    .XLEN       (XLEN),
    .ADDR_LIMIT (ADDR_LIMIT)
  ) u_addr_check (
    .is_store (bus.req_is_store),
    .funct3   (bus.req_funct3),
    .base     (bus.req_base),
    .offset   (bus.req_offset),
    .addr     (chk_addr),
    .err      (chk_err)
  );

  // Strobes are set on the accept edge so they are high exactly during ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= ST_IDLE;
      dropped               <= 1'b0;
      is_store_q            <= 1'b0;
      funct3_q              <= '0;
      rd_q                  <= '0;
      bus.req_ready         <= 1'b1;
      bus.resp_valid        <= 1'b0;
      bus.resp_data         <= '0;
      bus.resp_rd           <= '0;
      bus.resp_err          <= '0;
      bus.load_type         <= '0;
      bus.store_type        <= '0;
      bus.mem_read_en       <= 1'b0;
      bus.mem_write_en      <= 1'b0;
      bus.ram_address_load  <= '0;
      bus.ram_address_store <= '0;
      bus.data_in           <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid && !bus.flush) begin
            is_store_q    <= bus.req_is_store;
            funct3_q      <= bus.req_funct3;
            rd_q          <= bus.req_rd;
            dropped       <= 1'b0;
            bus.req_ready <= 1'b0;
            if (chk_err != ERR_NONE) begin
              state          <= ST_RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_data  <= '0;
              bus.resp_rd    <= bus.req_is_store ? 5'd0 : bus.req_rd;
              bus.resp_err   <= chk_err;
            end else begin
              state <= ST_ISSUE;
              if (bus.req_is_store) begin
                bus.mem_write_en      <= 1'b1;
                bus.store_type        <= bus.req_funct3;
                bus.ram_address_store <= chk_addr;
                bus.data_in           <= bus.req_wdata;
              end else begin
                bus.mem_read_en      <= 1'b1;
                bus.load_type        <= bus.req_funct3;
                bus.ram_address_load <= chk_addr;
              end
            end
          end
        end
        ST_ISSUE: begin
          bus.mem_read_en  <= 1'b0;
          bus.mem_write_en <= 1'b0;
          bus.load_type    <= '0;
          bus.store_type   <= '0;
          state            <= ST_WAIT;
          if (bus.flush) dropped <= 1'b1;
        end
        ST_WAIT: begin
          // A flushed access still completes at memory; only the response is suppressed.
          if (bus.mem_busy) begin
            if (bus.flush || dropped) begin
              state         <= ST_IDLE;
              bus.req_ready <= 1'b1;
            end else begin
              state          <= ST_RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_data  <= is_store_q ? '0 : load_adjust(funct3_q, bus.data_out);
              bus.resp_rd    <= is_store_q ? 5'd0 : rd_q;
              bus.resp_err   <= ERR_NONE;
            end
          end else if (bus.flush) begin
            dropped <= 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.flush || bus.resp_ready) begin
            state          <= ST_IDLE;
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
